// File: rtl/pf_req_queue.sv
// rtl/pf_req_queue.sv - prefetch request queue between the data prefetch predictor and the L2 cache
module pf_req_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int HIST        = 4,
    parameter int LINE_OFFSET = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_req,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [5:0]            in_pdch,
    input  logic                  dmd_valid,
    input  logic [ADDR_WIDTH-1:0] dmd_addr,
    output logic                  pf_valid,
    input  logic                  pf_ready,
    output logic [ADDR_WIDTH-1:0] pf_addr,
    output logic [ADDR_WIDTH-1:0] pf_pc,
    output logic [5:0]            pf_pdch,
    output logic                  q_full,
    output logic                  q_empty,
    output logic [15:0]           drop_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = (HIST > 1) ? $clog2(HIST) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << LINE_OFFSET) - ADDR_WIDTH'(1));

    // Queue storage: the valid bit doubles as the cancel flag for demand-covered lines
    logic [DEPTH-1:0]      e_valid;
    logic [ADDR_WIDTH-1:0] e_line [DEPTH];
    logic [ADDR_WIDTH-1:0] e_pc   [DEPTH];
    logic [5:0]            e_pdch [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    // Recently issued lines, overwritten oldest-first
    logic [HIST-1:0]       h_valid;
    logic [ADDR_WIDTH-1:0] h_line [HIST];
    logic [HW-1:0]         h_ptr;

    logic [ADDR_WIDTH-1:0] in_line;
    logic [ADDR_WIDTH-1:0] dmd_line;
    logic                  head_valid;
    logic                  pop;
    logic                  retire;
    logic                  room;
    logic                  q_hit;
    logic                  h_hit;
    logic                  d_hit;
    logic                  dup;
    logic                  push;
    logic                  drop;
    logic [DEPTH-1:0]      cancel;
    logic [DEPTH-1:0]      e_valid_nxt;

    assign in_line    = in_addr & LINE_MASK;
    assign dmd_line   = dmd_addr & LINE_MASK;
    assign head_valid = e_valid[head];

    // Outputs are driven only from registered state, so in_* never reaches pf_* in the same cycle
    assign pf_valid = (count != '0) && head_valid;
    assign pf_addr  = e_line[head];
    assign pf_pc    = e_pc[head];
    assign pf_pdch  = e_pdch[head];
    assign q_full   = (count == DEPTH_C);
    assign q_empty  = (count == '0);

    assign pop    = pf_valid && pf_ready;
    assign retire = (count != '0) && !head_valid;
    assign room   = (count != DEPTH_C) || pop || retire;

    // Redundancy filter: queued, recently issued, or covered by the demand access this cycle
    always_comb begin
        q_hit = 1'b0;
        h_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && (e_line[i] == in_line)) begin
                q_hit = 1'b1;
            end
        end
        for (int j = 0; j < HIST; j++) begin
            if (h_valid[j] && (h_line[j] == in_line)) begin
                h_hit = 1'b1;
            end
        end
        d_hit = dmd_valid && (dmd_line == in_line);
        dup   = q_hit || h_hit || d_hit;
        push  = in_req && !dup && room && !flush;
        drop  = in_req && !dup && !room && !flush;
    end

    // Next valid vector: demand cancel of non-head entries, then pop clear, then push set
    always_comb begin
        cancel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dmd_valid && e_valid[i] && (e_line[i] == dmd_line) && (head != PW'(i))) begin
                cancel[i] = 1'b1;
            end
        end
        e_valid_nxt = e_valid & ~cancel;
        if (pop) begin
            e_valid_nxt[head] = 1'b0;
        end
        if (push) begin
            e_valid_nxt[tail] = 1'b1;
        end
    end

    // Queue pointers, occupancy, entry payloads and the drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            e_valid  <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_line[i] <= '0;
                e_pc[i]   <= '0;
                e_pdch[i] <= '0;
            end
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
        end else begin
            e_valid <= e_valid_nxt;
            if (push) begin
                e_line[tail] <= in_line;
                e_pc[tail]   <= in_pc;
                e_pdch[tail] <= in_pdch;
                tail         <= tail + PW'(1);
            end
            if (pop || retire) begin
                head <= head + PW'(1);
            end
            if (push && !(pop || retire)) begin
                count <= count + CW'(1);
            end else if (!push && (pop || retire)) begin
                count <= count - CW'(1);
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Issued-line history, written on every completed handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_valid <= '0;
            h_ptr   <= '0;
            for (int j = 0; j < HIST; j++) begin
                h_line[j] <= '0;
            end
        end else if (flush) begin
            h_valid <= '0;
            h_ptr   <= '0;
        end else if (pop) begin
            h_line[h_ptr]  <= e_line[head];
            h_valid[h_ptr] <= 1'b1;
            if (h_ptr == HW'(HIST - 1)) begin
                h_ptr <= '0;
            end else begin
                h_ptr <= h_ptr + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pf_req_queue.sv
// tb/tb_pf_req_queue.sv - directed vector bench for pf_req_queue
module tb_pf_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_req;
    logic [31:0] in_addr;
    logic [31:0] in_pc;
    logic [5:0]  in_pdch;
    logic        dmd_valid;
    logic [31:0] dmd_addr;
    logic        pf_valid;
    logic        pf_ready;
    logic [31:0] pf_addr;
    logic [31:0] pf_pc;
    logic [5:0]  pf_pdch;
    logic        q_full;
    logic        q_empty;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pf_req_queue #(.ADDR_WIDTH(32), .DEPTH(4), .HIST(4), .LINE_OFFSET(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_req(in_req), .in_addr(in_addr), .in_pc(in_pc), .in_pdch(in_pdch),
        .dmd_valid(dmd_valid), .dmd_addr(dmd_addr),
        .pf_valid(pf_valid), .pf_ready(pf_ready), .pf_addr(pf_addr),
        .pf_pc(pf_pc), .pf_pdch(pf_pdch),
        .q_full(q_full), .q_empty(q_empty), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        rq;
        logic [31:0] a;
        logic        dv;
        logic [31:0] da;
        logic        rdy;
        logic        e_pv;
        logic [31:0] e_addr;
        logic        e_full;
        logic        e_empty;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic fl, input logic rq, input logic [31:0] a,
                                input logic dv, input logic [31:0] da, input logic rdy,
                                input logic pv, input logic [31:0] ea,
                                input logic full, input logic empty, input logic [15:0] drop);
        vec_t v;
        v.fl = fl; v.rq = rq; v.a = a; v.dv = dv; v.da = da; v.rdy = rdy;
        v.e_pv = pv; v.e_addr = ea; v.e_full = full; v.e_empty = empty; v.e_drop = drop;
        vecs.push_back(v);
    endfunction

    // Tag model: pc and pdch are derived from the pushed line so the echo can be predicted
    function automatic logic [31:0] pc_of(input logic [31:0] a);
        return {a[31:6], 6'h0} ^ 32'hFFFF_0000;
    endfunction

    function automatic logic [5:0] pdch_of(input logic [31:0] a);
        return a[11:6];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush = 0; in_req = 0; in_addr = 0; in_pc = 0; in_pdch = 0;
        dmd_valid = 0; dmd_addr = 0; pf_ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();

        //   fl rq addr          dv da        rdy pv addr          full empty drop
        // basic push / issue
        add(0, 0, 32'h0,         0, 32'h0,    1,  0, 32'h0,         0, 1, 16'd0);   // v0
        add(0, 1, 32'h1000_0048, 0, 32'h0,    1,  0, 32'h0,         0, 1, 16'd0);   // v1
        add(0, 0, 32'h0,         0, 32'h0,    1,  1, 32'h1000_0040, 0, 0, 16'd0);   // v2
        add(0, 0, 32'h0,         0, 32'h0,    1,  0, 32'h0,         0, 1, 16'd0);   // v3
        // fill under stall, overflow drop, dup on queued line while full
        add(0, 1, 32'h2000,      0, 32'h0,    0,  0, 32'h0,         0, 1, 16'd0);   // v4
        add(0, 1, 32'h2040,      0, 32'h0,    0,  1, 32'h2000,      0, 0, 16'd0);   // v5
        add(0, 1, 32'h2080,      0, 32'h0,    0,  1, 32'h2000,      0, 0, 16'd0);   // v6
        add(0, 1, 32'h20C0,      0, 32'h0,    0,  1, 32'h2000,      0, 0, 16'd0);   // v7
        add(0, 1, 32'h2100,      0, 32'h0,    0,  1, 32'h2000,      1, 0, 16'd0);   // v8
        add(0, 1, 32'h2010,      0, 32'h0,    0,  1, 32'h2000,      1, 0, 16'd1);   // v9
        add(0, 0, 32'h0,         0, 32'h0,    1,  1, 32'h2000,      1, 0, 16'd1);   // v10
        add(0, 0, 32'h0,         0, 32'h0,    1,  1, 32'h2040,      0, 0, 16'd1);   // v11
        add(0, 0, 32'h0,         0, 32'h0,    1,  1, 32'h2080,      0, 0, 16'd1);   // v12
        add(0, 0, 32'h0,         0, 32'h0,    1,  1, 32'h20C0,      0, 0, 16'd1);   // v13
        add(0, 0, 32'h0,         0, 32'h0,    0,  0, 32'h0,         0, 1, 16'd1);   // v14
        // dup against popping head, history and demand
        add(0, 1, 32'h3000,      0, 32'h0,    1,  0, 32'h0,         0, 1, 16'd1);   // v15
        add(0, 1, 32'h3020,      0, 32'h0,    1,  1, 32'h3000,      0, 0, 16'd1);   // v16
        add(0, 1, 32'h3010,      0, 32'h0,    1,  0, 32'h0,         0, 1, 16'd1);   // v17
        add(0, 0, 32'h0,         0, 32'h0,    1,  0, 32'h0,         0, 1, 16'd1);   // v18
        add(0, 1, 32'h3800,      1, 32'h3820, 1,  0, 32'h0,         0, 1, 16'd1);   // v19
        add(0, 0, 32'h0,         0, 32'h0,    1,  0, 32'h0,         0, 1, 16'd1);   // v20
        // demand cancel of a non-head entry, then silent retire
        add(0, 1, 32'h4000,      0, 32'h0,    0,  0, 32'h0,         0, 1, 16'd1);   // v21
        add(0, 1, 32'h4040,      0, 32'h0,    0,  1, 32'h4000,      0, 0, 16'd1);   // v22
        add(0, 0, 32'h0,         1, 32'h4044, 0,  1, 32'h4000,      0, 0, 16'd1);   // v23
        add(0, 0, 32'h0,         0, 32'h0,    1,  1, 32'h4000,      0, 0, 16'd1);   // v24
        add(0, 0, 32'h0,         0, 32'h0,    1,  0, 32'h0,         0, 0, 16'd1);   // v25
        add(0, 0, 32'h0,         0, 32'h0,    1,  0, 32'h0,         0, 1, 16'd1);   // v26
        // full with simultaneous pop and push
        add(0, 1, 32'h5000,      0, 32'h0,    0,  0, 32'h0,         0, 1, 16'd1);   // v27
        add(0, 1, 32'h5040,      0, 32'h0,    0,  1, 32'h5000,      0, 0, 16'd1);   // v28
        add(0, 1, 32'h5080,      0, 32'h0,    0,  1, 32'h5000,      0, 0, 16'd1);   // v29
        add(0, 1, 32'h50C0,      0, 32'h0,    0,  1, 32'h5000,      0, 0, 16'd1);   // v30
        add(0, 1, 32'h5100,      0, 32'h0,    1,  1, 32'h5000,      1, 0, 16'd1);   // v31
        add(0, 0, 32'h0,         0, 32'h0,    0,  1, 32'h5040,      1, 0, 16'd1);   // v32
        // flush with three entries queued; history cleared, drop_cnt kept
        add(0, 0, 32'h0,         0, 32'h0,    1,  1, 32'h5040,      1, 0, 16'd1);   // v33
        add(1, 1, 32'h6000,      0, 32'h0,    0,  1, 32'h5080,      0, 0, 16'd1);   // v34
        add(0, 0, 32'h0,         0, 32'h0,    0,  0, 32'h0,         0, 1, 16'd1);   // v35
        add(0, 1, 32'h5000,      0, 32'h0,    0,  0, 32'h0,         0, 1, 16'd1);   // v36
        add(0, 0, 32'h0,         0, 32'h0,    0,  1, 32'h5000,      0, 0, 16'd1);   // v37

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset pf_valid", {31'h0, pf_valid}, 32'h0);
        chk("reset q_empty", {31'h0, q_empty}, 32'h1);
        chk("reset pf_addr", pf_addr, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            flush     = vecs[i].fl;
            in_req    = vecs[i].rq;
            in_addr   = vecs[i].a;
            in_pc     = pc_of(vecs[i].a);
            in_pdch   = pdch_of(vecs[i].a);
            dmd_valid = vecs[i].dv;
            dmd_addr  = vecs[i].da;
            pf_ready  = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d pf_valid", i), {31'h0, pf_valid}, {31'h0, vecs[i].e_pv});
            chk($sformatf("v%0d q_full", i), {31'h0, q_full}, {31'h0, vecs[i].e_full});
            chk($sformatf("v%0d q_empty", i), {31'h0, q_empty}, {31'h0, vecs[i].e_empty});
            chk($sformatf("v%0d drop_cnt", i), {16'h0, drop_cnt}, {16'h0, vecs[i].e_drop});
            if (vecs[i].e_pv) begin
                chk($sformatf("v%0d pf_addr", i), pf_addr, vecs[i].e_addr);
                chk($sformatf("v%0d pf_pc", i), pf_pc, pc_of(vecs[i].e_addr));
                chk($sformatf("v%0d pf_pdch", i), {26'h0, pf_pdch}, {26'h0, pdch_of(vecs[i].e_addr)});
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Async reset in the middle of a stalled handshake
        drive_idle();
        #1;
        chk("stall before rst pf_valid", {31'h0, pf_valid}, 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst pf_valid", {31'h0, pf_valid}, 32'h0);
        chk("async rst q_empty", {31'h0, q_empty}, 32'h1);
        chk("async rst drop_cnt", {16'h0, drop_cnt}, 32'h0);
        chk("async rst pf_addr", pf_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post rst pf_valid", {31'h0, pf_valid}, 32'h0);

        // Latency after reset: push lands, output one cycle later
        @(negedge clk);
        in_req = 1; in_addr = 32'h7000_007F; in_pc = pc_of(32'h7000_0040); in_pdch = pdch_of(32'h7000_0040);
        #1;
        chk("latency same cycle pf_valid", {31'h0, pf_valid}, 32'h0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("latency next cycle pf_valid", {31'h0, pf_valid}, 32'h1);
        chk("latency next cycle pf_addr", pf_addr, 32'h7000_0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pf_req_queue.md
Name: pf_req_queue

Overview:
- Sits directly downstream of the data prefetch predictor. Consumes its per-cycle prefetch suggestion (naddr/req/pdch) and buffers it in a small FIFO.
- Drops redundant requests: duplicates of queued lines, duplicates of recently issued lines, and lines already covered by a demand access.
- Issues surviving line addresses to the L2 cache over a valid/ready handshake.
- Forwards the predictor's pc and pdch tag with each request so the L2 side can return update information.

Parameters:
- ADDR_WIDTH, 32, address and pc width.
- DEPTH, 4, queue entries (power of 2, ≥2).
- HIST, 4, recently-issued line history entries (power of 2).
- LINE_OFFSET, 6, low address bits cleared to form a line address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of queue and history.
- in_req  in  1  predictor prefetch request valid.
- in_addr  in  ADDR_WIDTH  predicted address (naddr_pdc).
- in_pc  in  ADDR_WIDTH  pc of the triggering load.
- in_pdch  in  6  predictor state tag {hit,spare,choice}.
- dmd_valid  in  1  demand access observed this cycle.
- dmd_addr  in  ADDR_WIDTH  demand address.
- pf_valid  out  1  prefetch request to L2 valid.
- pf_ready  in  1  L2 accepts request.
- pf_addr  out  ADDR_WIDTH  line-aligned prefetch address.
- pf_pc  out  ADDR_WIDTH  pc tag of the head entry.
- pf_pdch  out  6  pdch tag of the head entry.
- q_full  out  1  count == DEPTH.
- q_empty  out  1  count == 0.
- drop_cnt  out  16  saturating count of requests lost to a full queue.

Behaviour:
- Reset (async, rst=1):
  - head, tail and count = 0; all entry and history valid bits = 0; drop_cnt = 0.
  - pf_valid = 0, q_empty = 1, q_full = 0; pf_addr, pf_pc, pf_pdch = 0.
  - Reset asserted mid-handshake abandons the request. L2 must not see pf_valid after the reset edge.
- Line address: line(x) = x with bits [LINE_OFFSET-1:0] cleared. All compares use line addresses. pf_addr is always line-aligned.
- Entry: {valid, line, pc, pdch}. The queue is circular, with head/tail pointers wrapping modulo DEPTH.
- pop = pf_valid & pf_ready.
- retire = count>0 & head entry valid==0. An invalid (cancelled) head is removed with no handshake, one per cycle.
- dup: asserted when line(in_addr) matches any of:
  - any valid queue entry;
  - any valid history entry;
  - line(dmd_addr) when dmd_valid.
- Push rule:
  - Push when in_req & ~dup & (count<DEPTH | pop | retire).
  - If in_req & ~dup & queue full with no pop/retire: the request is dropped and drop_cnt increments, saturating at 0xFFFF.
  - Dup requests are silently discarded and are not counted.
- Latency: a request pushed at edge N can give pf_valid=1 in cycle N+1 at the earliest. There is no combinational path from in_* to pf_*.
- pf_valid = count>0 & head valid. pf_addr/pf_pc/pf_pdch come from the head entry.
- Stability: while pf_valid=1 and pf_ready=0, the head entry and all pf_* outputs hold unchanged.
- Demand cancel: when dmd_valid, every valid non-head entry whose line equals line(dmd_addr) has its valid bit cleared at the edge. The head entry is never cancelled once pf_valid has been asserted for it.
- History:
  - On pop, the head line is written into the history at hist_ptr, which then increments (wrap modulo HIST). The oldest history entry is overwritten.
  - A request matching the entry being popped in the same cycle is still treated as dup.
- count changes by +1 on push, −1 on pop or retire. pop and retire never occur in the same cycle.
- q_full and q_empty are derived from the registered count.
- Flush: at the edge, head, tail, count, entry valids and history valids are cleared, and pf_valid drops the next cycle. drop_cnt is kept. A push in the flush cycle is ignored. flush takes priority over every other event.

Test Plan:
- Reset, then in_req=1 with in_addr=0x1000_0048 for one cycle, pf_ready=1 → pf_valid=1 one cycle later with pf_addr=0x1000_0040, pf_pc/pf_pdch echoed; q_empty returns to 1 after the pop.
- pf_ready=0, push 0x2000/0x2040/0x2080/0x20C0, then push 0x2100 → q_full=1, 0x2100 dropped, drop_cnt=1; pf_addr holds 0x2000 for the whole stall.
- Duplicates: push 0x3000 and issue it, then push 0x3010 → treated as dup; no pf_valid, drop_cnt unchanged.
- Demand cancel: queue holds 0x4000 (head, stalled) and 0x4040. dmd_valid with dmd_addr=0x4044 → 0x4040 invalidated. After pf_ready, 0x4000 issues, the invalid entry retires silently, and q_empty=1 two cycles later.
- Full plus simultaneous pop and push with pf_ready=1 → push accepted, count stays DEPTH, drop_cnt unchanged.
- Flush while 3 entries are queued, plus rst asserted asynchronously mid-stall → pf_valid=0 on the next edge for flush, and immediately for rst; after flush drop_cnt is kept, and a previously issued line is no longer dup.
